// File: rtl/mem_rr_arbiter_if.sv
// Requester, response and memory-pin bundle for mem_rr_arbiter.
// master: client/memory side; slave: the arbiter itself.
interface mem_rr_arbiter_if #(
  parameter int unsigned width = 5,
  parameter int unsigned depth = 4
);
  localparam int unsigned AW = $clog2(depth);

  logic             req0_valid;
  logic             req0_ready;
  logic             req0_we;
  logic [AW-1:0]    req0_addr;
  logic [width-1:0] req0_wdata;

  logic             req1_valid;
  logic             req1_ready;
  logic             req1_we;
  logic [AW-1:0]    req1_addr;
  logic [width-1:0] req1_wdata;

  logic             rsp0_valid;
  logic [width-1:0] rsp0_data;
  logic             rsp1_valid;
  logic [width-1:0] rsp1_data;

  logic             mem_wen;
  logic [AW-1:0]    mem_waddr;
  logic [width-1:0] mem_wdata;
  logic [AW-1:0]    mem_raddr;
  logic [width-1:0] mem_rdata;

  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata,
    output req1_valid, req1_we, req1_addr, req1_wdata,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
    input  mem_wen, mem_waddr, mem_wdata, mem_raddr,
    output mem_rdata
  );

  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata,
    input  req1_valid, req1_we, req1_addr, req1_wdata,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
    output mem_wen, mem_waddr, mem_wdata, mem_raddr,
    input  mem_rdata
  );
endinterface

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one sync-read memory between two requesters;
// read data returns one cycle after grant, tagged to the issuing requester.
module mem_rr_arbiter #(
  parameter int unsigned width = 5,
  parameter int unsigned depth = 4
) (
  input logic             clk,
  input logic             arst,
  mem_rr_arbiter_if.slave bus
);
  localparam int unsigned AW = $clog2(depth);

  logic             gnt0;
  logic             gnt1;
  logic             xfer;
  logic             sel_id;
  logic             sel_we;
  logic [AW-1:0]    sel_addr;
  logic [width-1:0] sel_wdata;

  logic last_grant_q, last_grant_d;
  logic rsp_pend_q, rsp_pend_d;
  logic rsp_id_q, rsp_id_d;

  // Grants are masked while reset is held so nothing transfers during reset.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!arst) begin
      unique case ({bus.req1_valid, bus.req0_valid})
        2'b01: gnt0 = 1'b1;
        2'b10: gnt1 = 1'b1;
        2'b11: begin
          if (last_grant_q) gnt0 = 1'b1;
          else              gnt1 = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    xfer      = gnt0 | gnt1;
    sel_id    = gnt1;
    sel_we    = gnt1 ? bus.req1_we    : bus.req0_we;
    sel_addr  = gnt1 ? bus.req1_addr  : bus.req0_addr;
    sel_wdata = gnt1 ? bus.req1_wdata : bus.req0_wdata;
  end

  always_comb begin
    bus.req0_ready = gnt0;
    bus.req1_ready = gnt1;
    bus.mem_wen    = xfer & sel_we;
    bus.mem_waddr  = (xfer & sel_we)  ? sel_addr  : '0;
    bus.mem_wdata  = (xfer & sel_we)  ? sel_wdata : '0;
    bus.mem_raddr  = (xfer & ~sel_we) ? sel_addr  : '0;
  end

  always_comb begin
    bus.rsp0_valid = rsp_pend_q & ~rsp_id_q;
    bus.rsp1_valid = rsp_pend_q &  rsp_id_q;
    bus.rsp0_data  = bus.rsp0_valid ? bus.mem_rdata : '0;
    bus.rsp1_data  = bus.rsp1_valid ? bus.mem_rdata : '0;
  end

  always_comb begin
    last_grant_d = xfer ? sel_id : last_grant_q;
    rsp_pend_d   = xfer & ~sel_we;
    rsp_id_d     = (xfer & ~sel_we) ? sel_id : rsp_id_q;
  end

  // Reset value 1 lets requester 0 win the first contention.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      last_grant_q <= 1'b1;
      rsp_pend_q   <= 1'b0;
      rsp_id_q     <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      rsp_pend_q   <= rsp_pend_d;
      rsp_id_q     <= rsp_id_d;
    end
  end
endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed bench for mem_rr_arbiter: a sync-read memory behind the arbiter, a
// per-cycle reference model, and hand-computed expectations for each scenario.
module tb_mem_rr_arbiter;
  localparam int unsigned W = 5;
  localparam int unsigned D = 4;

  logic clk = 1'b0;
  logic arst;
  logic chk_en;
  int   n_tests = 0;
  int   n_fail  = 0;

  mem_rr_arbiter_if #(.width(W), .depth(D)) bus ();

  mem_rr_arbiter #(.width(W), .depth(D)) dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Memory instance behind the arbiter, preloaded {11,21,0,5} at addr 3..0.
  logic [W-1:0] mem_arr [D];
  initial begin
    mem_arr[0] = 5'd5;
    mem_arr[1] = 5'd0;
    mem_arr[2] = 5'd21;
    mem_arr[3] = 5'd11;
    bus.mem_rdata = '0;
  end
  always @(posedge clk) begin
    if (bus.mem_wen) mem_arr[bus.mem_waddr] <= bus.mem_wdata;
    bus.mem_rdata <= mem_arr[bus.mem_raddr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who should win, what the memory pins carry, and which
  // response is due, derived from the arbitration rules and a word array.
  logic [W-1:0] m_mem [D];
  logic         m_last = 1'b1;
  logic         m_pend = 1'b0;
  logic         m_id   = 1'b0;
  logic [W-1:0] m_data = '0;
  logic         e_g0, e_g1, e_x, e_we;
  logic [1:0]   e_addr;
  logic [W-1:0] e_wd;

  initial begin
    m_mem[0] = 5'd5;
    m_mem[1] = 5'd0;
    m_mem[2] = 5'd21;
    m_mem[3] = 5'd11;
  end

  always @(posedge arst) begin
    m_last = 1'b1;
    m_pend = 1'b0;
    m_id   = 1'b0;
  end

  always @(negedge clk) begin
    if (chk_en && !arst) begin
      e_g0   = bus.req0_valid && (!bus.req1_valid || m_last);
      e_g1   = bus.req1_valid && (!bus.req0_valid || !m_last);
      e_x    = e_g0 || e_g1;
      e_we   = e_g1 ? bus.req1_we    : bus.req0_we;
      e_addr = e_g1 ? bus.req1_addr  : bus.req0_addr;
      e_wd   = e_g1 ? bus.req1_wdata : bus.req0_wdata;
      chk("m_req0_ready", 32'(bus.req0_ready), 32'(e_g0));
      chk("m_req1_ready", 32'(bus.req1_ready), 32'(e_g1));
      chk("m_mem_wen",    32'(bus.mem_wen),    32'(e_x && e_we));
      chk("m_mem_waddr",  32'(bus.mem_waddr),  (e_x && e_we)  ? 32'(e_addr) : 32'd0);
      chk("m_mem_wdata",  32'(bus.mem_wdata),  (e_x && e_we)  ? 32'(e_wd)   : 32'd0);
      chk("m_mem_raddr",  32'(bus.mem_raddr),  (e_x && !e_we) ? 32'(e_addr) : 32'd0);
      chk("m_rsp0_valid", 32'(bus.rsp0_valid), 32'(m_pend && !m_id));
      chk("m_rsp1_valid", 32'(bus.rsp1_valid), 32'(m_pend && m_id));
      chk("m_rsp0_data",  32'(bus.rsp0_data),  (m_pend && !m_id) ? 32'(m_data) : 32'd0);
      chk("m_rsp1_data",  32'(bus.rsp1_data),  (m_pend && m_id)  ? 32'(m_data) : 32'd0);
      // Inputs are stable until after the next rising edge: advance now.
      m_pend = e_x && !e_we;
      if (e_x && !e_we) begin
        m_id   = e_g1;
        m_data = m_mem[e_addr];
      end
      if (e_x && e_we) m_mem[e_addr] = e_wd;
      if (e_x) m_last = e_g1;
    end
  end

  task automatic req(input int id, input logic v, input logic we, input logic [1:0] a,
                     input logic [W-1:0] d);
    if (id == 0) begin
      bus.req0_valid = v; bus.req0_we = we; bus.req0_addr = a; bus.req0_wdata = d;
    end else begin
      bus.req1_valid = v; bus.req1_we = we; bus.req1_addr = a; bus.req1_wdata = d;
    end
  endtask

  task automatic idle();
    req(0, 1'b0, 1'b0, 2'd0, 5'd0);
    req(1, 1'b0, 1'b0, 2'd0, 5'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    chk_en = 1'b0;
    arst   = 1'b0;
    idle();
    #2 arst = 1'b1;
    repeat (2) @(posedge clk);
    #1 arst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_req0_ready", 32'(bus.req0_ready), 32'd0);
    chk("rst_req1_ready", 32'(bus.req1_ready), 32'd0);
    chk("rst_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
    chk("rst_rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
    chk("rst_mem_wen",    32'(bus.mem_wen),    32'd0);
    chk("rst_mem_raddr",  32'(bus.mem_raddr),  32'd0);

    // 1: lone read of addr1 by requester 0.
    step(); req(0, 1'b1, 1'b0, 2'd1, 5'd0);
    @(negedge clk);
    chk("t1_ready0", 32'(bus.req0_ready), 32'd1);
    chk("t1_raddr",  32'(bus.mem_raddr),  32'd1);
    step(); idle();
    @(negedge clk);
    chk("t1_rsp0_valid", 32'(bus.rsp0_valid), 32'd1);
    chk("t1_rsp0_data",  32'(bus.rsp0_data),  32'd0);
    chk("t1_rsp1_valid", 32'(bus.rsp1_valid), 32'd0);

    // Lone requester-1 read hands last_grant back to 1.
    step(); req(1, 1'b1, 1'b0, 2'd2, 5'd0);
    @(negedge clk);
    chk("f_ready1", 32'(bus.req1_ready), 32'd1);
    step(); idle();
    @(negedge clk);
    chk("f_rsp1_data", 32'(bus.rsp1_data), 32'd21);

    // 2: continuous contention alternates 0,1,0,1.
    step(); req(0, 1'b1, 1'b0, 2'd0, 5'd0); req(1, 1'b1, 1'b0, 2'd3, 5'd0);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        step();
        if (i == 4) idle();
      end
      @(negedge clk);
      if (i < 4) begin
        chk("t2_ready0", 32'(bus.req0_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
        chk("t2_ready1", 32'(bus.req1_ready), (i % 2 == 1) ? 32'd1 : 32'd0);
      end
      if (i > 0) begin
        chk("t2_rsp0_data", 32'(bus.rsp0_data), ((i - 1) % 2 == 0) ? 32'd5  : 32'd0);
        chk("t2_rsp1_data", 32'(bus.rsp1_data), ((i - 1) % 2 == 1) ? 32'd11 : 32'd0);
      end
    end

    // 3: write-then-read of the same address returns the new word.
    step(); req(1, 1'b1, 1'b1, 2'd2, 5'd17);
    @(negedge clk);
    chk("t3_wen",    32'(bus.mem_wen),    32'd1);
    chk("t3_waddr",  32'(bus.mem_waddr),  32'd2);
    chk("t3_wdata",  32'(bus.mem_wdata),  32'd17);
    chk("t3_ready1", 32'(bus.req1_ready), 32'd1);
    step(); req(1, 1'b0, 1'b0, 2'd0, 5'd0); req(0, 1'b1, 1'b0, 2'd2, 5'd0);
    @(negedge clk);
    chk("t3_ready0", 32'(bus.req0_ready), 32'd1);
    chk("t3_raddr",  32'(bus.mem_raddr),  32'd2);
    step(); idle();
    @(negedge clk);
    chk("t3_rsp0_valid", 32'(bus.rsp0_valid), 32'd1);
    chk("t3_rsp0_data",  32'(bus.rsp0_data),  32'd17);

    // 4: last_grant=0, req0 write vs req1 read -> req1 first.
    step(); req(0, 1'b1, 1'b1, 2'd0, 5'd9); req(1, 1'b1, 1'b0, 2'd3, 5'd0);
    @(negedge clk);
    chk("t4a_ready1", 32'(bus.req1_ready), 32'd1);
    chk("t4a_ready0", 32'(bus.req0_ready), 32'd0);
    chk("t4a_raddr",  32'(bus.mem_raddr),  32'd3);
    step(); req(1, 1'b0, 1'b0, 2'd0, 5'd0);
    @(negedge clk);
    chk("t4b_ready0",    32'(bus.req0_ready), 32'd1);
    chk("t4b_ready1",    32'(bus.req1_ready), 32'd0);
    chk("t4b_wdata",     32'(bus.mem_wdata),  32'd9);
    chk("t4b_rsp1_data", 32'(bus.rsp1_data),  32'd11);
    step(); idle();

    // 5: reset after a granted read drops its response and restores req0 priority.
    step(); req(0, 1'b1, 1'b0, 2'd1, 5'd0);
    @(negedge clk);
    chk("t5_ready0", 32'(bus.req0_ready), 32'd1);
    step(); arst = 1'b1; idle(); #2 arst = 1'b0;
    @(negedge clk);
    chk("t5_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
    chk("t5_rsp0_data",  32'(bus.rsp0_data),  32'd0);
    step(); req(0, 1'b1, 1'b0, 2'd2, 5'd0); req(1, 1'b1, 1'b0, 2'd3, 5'd0);
    @(negedge clk);
    chk("t5_prio_ready0", 32'(bus.req0_ready), 32'd1);
    chk("t5_prio_ready1", 32'(bus.req1_ready), 32'd0);
    step(); req(0, 1'b0, 1'b0, 2'd0, 5'd0);
    @(negedge clk);
    chk("t5_ready1",    32'(bus.req1_ready), 32'd1);
    chk("t5_rsp0_data", 32'(bus.rsp0_data),  32'd17);
    step(); idle();
    @(negedge clk);
    chk("t5_rsp1_data", 32'(bus.rsp1_data), 32'd11);

    // 6: idle cycles keep every output quiet and last_grant (=1) unchanged.
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      chk("t6_wen",        32'(bus.mem_wen),    32'd0);
      chk("t6_waddr",      32'(bus.mem_waddr),  32'd0);
      chk("t6_wdata",      32'(bus.mem_wdata),  32'd0);
      chk("t6_raddr",      32'(bus.mem_raddr),  32'd0);
      chk("t6_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
      chk("t6_rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
    end
    step(); req(0, 1'b1, 1'b0, 2'd0, 5'd0); req(1, 1'b1, 1'b0, 2'd1, 5'd0);
    @(negedge clk);
    chk("t6_ready0", 32'(bus.req0_ready), 32'd1);
    step(); idle();
    @(negedge clk);
    chk("t6_rsp0_data", 32'(bus.rsp0_data), 32'd9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
